// File: rtl/piso_shift_reg_p.sv
// Parametrised parallel-in serial-out shift register with valid/ready on both sides.
// Optional build macro PARITY_EN appends an even-parity beat to every word.
module piso_shift_reg_p #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic             msb_first,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1
`ifdef PARITY_EN
        ,
        S_PARITY = 2'd2
`endif
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_shift;
    logic               r_msb;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_frame_done;
    logic               w_frame_end;
    logic               w_load;
    logic               w_last_bit;
`ifdef PARITY_EN
    logic               r_parity;
`endif

    assign w_last_bit = (r_cnt == CNT_W'(1));
    assign w_load     = load_valid & load_ready;
    assign frame_done = r_frame_done;

    always_comb begin
        w_next      = r_state;
        load_ready  = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = 1'b0;
        busy        = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                busy      = 1'b1;
                ser_out   = r_msb ? r_shift[WIDTH-1] : r_shift[0];
`ifdef PARITY_EN
                if (ser_ready && w_last_bit) w_next = S_PARITY;
`else
                // Accepting the next word on the last beat keeps the stream gap-free.
                load_ready = w_last_bit & ser_ready;
                if (ser_ready && w_last_bit) begin
                    w_frame_end = 1'b1;
                    w_next      = load_valid ? S_SHIFT : S_IDLE;
                end
`endif
            end
`ifdef PARITY_EN
            S_PARITY: begin
                ser_valid  = 1'b1;
                busy       = 1'b1;
                ser_out    = r_parity;
                load_ready = ser_ready;
                if (ser_ready) begin
                    w_frame_end = 1'b1;
                    w_next      = load_valid ? S_SHIFT : S_IDLE;
                end
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_shift      <= '0;
            r_msb        <= 1'b0;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
`ifdef PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_state      <= w_next;
            r_frame_done <= w_frame_end;
            if (w_load) begin
                r_shift  <= load_data;
                r_msb    <= msb_first;
                r_cnt    <= CNT_W'(WIDTH);
`ifdef PARITY_EN
                r_parity <= ^load_data;
`endif
            end else if (r_state == S_SHIFT && ser_ready) begin
                r_shift <= r_msb ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
                r_cnt   <= r_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_piso_shift_reg_p.sv
// Bench for piso_shift_reg_p: bit-queue reference model checked every cycle,
// plus literal expectations on captured serial streams. Honours PARITY_EN.
module tb_piso_shift_reg_p;

    localparam int WIDTH = 8;
`ifdef PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL = WIDTH + PB;

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             msb_first;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             busy;
    logic             frame_done;

    piso_shift_reg_p #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .msb_first  (msb_first),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word becomes a queue of output beats.
    typedef struct packed {
        logic b;
        logic last;
    } beat_t;
    beat_t q[$];
    logic  exp_fd  = 1'b0;
    logic  chk_en  = 1'b0;

    always @(posedge clk) begin
        logic rdy, bt, fdn;
        if (rst) begin
            q.delete();
            exp_fd = 1'b0;
        end else begin
            rdy = (q.size() == 0) || (q.size() == 1 && ser_ready);
            bt  = (q.size() > 0) && ser_ready;
            fdn = bt && q[0].last;
            if (bt) void'(q.pop_front());
            if (load_valid && rdy) begin
                for (int i = 0; i < WIDTH; i++) begin
                    beat_t e;
                    e.b    = msb_first ? load_data[WIDTH-1-i] : load_data[i];
                    e.last = (PB == 0) && (i == WIDTH - 1);
                    q.push_back(e);
                end
                if (PB == 1) begin
                    beat_t p;
                    p.b    = ^load_data;
                    p.last = 1'b1;
                    q.push_back(p);
                end
            end
            exp_fd = fdn;
        end
    end

    // Per-cycle compare plus stream capture, away from the active edge.
    logic [63:0] cap = '0;
    int          cap_n = 0;
    int          fd_cnt = 0;
    int          cyc = 0;
    int          first_cyc = 0;
    int          last_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (chk_en) begin
            chk("ser_valid", ser_valid, q.size() > 0);
            chk("busy", busy, q.size() > 0);
            chk("ser_out", ser_out, (q.size() > 0) ? q[0].b : 1'b0);
            chk("load_ready", load_ready, (q.size() == 0) || (q.size() == 1 && ser_ready));
            chk("frame_done", frame_done, exp_fd);
            if (!rst && ser_valid && ser_ready) begin
                if (cap_n == 0) first_cyc = cyc;
                last_cyc = cyc;
                cap = {cap[62:0], ser_out};
                cap_n++;
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        cap    = '0;
        cap_n  = 0;
        fd_cnt = 0;
    endtask

    task automatic load_word(input logic [WIDTH-1:0] w, input logic m);
        logic acc;
        acc        = 1'b0;
        load_valid = 1'b1;
        load_data  = w;
        msb_first  = m;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            acc = load_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) chk("load_timeout", 1'b0, 1'b1);
        load_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        for (k = 0; k < 200 && q.size() > 0; k++) tick();
        if (q.size() > 0) chk("drain_timeout", 1'b0, 1'b1);
        tick();
        tick();
    endtask

    logic [63:0] e_a5_msb, e_a5_lsb, e_01_lsb, e_c3, e_stream, e_07;
    int          pat [4] = '{1, 0, 0, 1};

    initial begin
`ifdef PARITY_EN
        e_a5_msb = 64'h14A;
        e_a5_lsb = 64'h14A;
        e_01_lsb = 64'h101;
        e_c3     = 64'h186;
        e_stream = 64'h3C01E;
        e_07     = 64'h00F;
`else
        e_a5_msb = 64'hA5;
        e_a5_lsb = 64'hA5;
        e_01_lsb = 64'h80;
        e_c3     = 64'hC3;
        e_stream = 64'hF00F;
        e_07     = 64'h07;
`endif
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        msb_first  = 1'b0;
        ser_ready  = 1'b1;

        // Reset state
        tick();
        chk_en = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ser_out", ser_out, 1'b0);
        chk("rst_ser_valid", ser_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_load_ready", load_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();

        // A5 MSB first
        clear_cap();
        load_word(8'hA5, 1'b1);
        drain();
        chk("a5_msb_bits", cap & ((64'd1 << FL) - 1), e_a5_msb);
        chk("a5_msb_count", cap_n, FL);
        chk("a5_msb_fd", fd_cnt, 1);

        // A5 and 01 LSB first
        clear_cap();
        load_word(8'hA5, 1'b0);
        drain();
        chk("a5_lsb_bits", cap & ((64'd1 << FL) - 1), e_a5_lsb);
        clear_cap();
        load_word(8'h01, 1'b0);
        drain();
        chk("01_lsb_bits", cap & ((64'd1 << FL) - 1), e_01_lsb);
        chk("01_lsb_count", cap_n, FL);

        // C3 with back-pressure
        clear_cap();
        load_word(8'hC3, 1'b1);
        for (int k = 0; k < 100 && q.size() > 0; k++) begin
            ser_ready = pat[k % 4][0];
            tick();
        end
        ser_ready = 1'b1;
        tick();
        tick();
        chk("c3_bits", cap & ((64'd1 << FL) - 1), e_c3);
        chk("c3_count", cap_n, FL);
        chk("c3_fd", fd_cnt, 1);

        // Back-to-back F0 then 0F
        clear_cap();
        load_word(8'hF0, 1'b1);
        load_word(8'h0F, 1'b1);
        drain();
        chk("stream_bits", cap & ((64'd1 << (2 * FL)) - 1), e_stream);
        chk("stream_count", cap_n, 2 * FL);
        chk("stream_span", last_cyc - first_cyc + 1, 2 * FL);
        chk("stream_fd", fd_cnt, 2);

        // Abort FF after 3 bits; a load during reset is discarded
        clear_cap();
        load_word(8'hFF, 1'b1);
        tick();
        tick();
        tick();
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'h55;
        tick();
        @(negedge clk);
        chk("abort_ser_valid", ser_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_fd", frame_done, 1'b0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("abort_idle", ser_valid, 1'b0);
        chk("abort_fd_cnt", fd_cnt, 0);
        chk("abort_bits", cap_n, 3);

        // 07: with parity the ninth beat is 1
        @(posedge clk);
        #1;
        clear_cap();
        load_word(8'h07, 1'b1);
        drain();
        chk("07_count", cap_n, FL);
        chk("07_bits", cap & ((64'd1 << FL) - 1), e_07);
        chk("07_last", cap[0], 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/piso_shift_reg_p.md
Name: piso_shift_reg_p

Overview:
Parametrised parallel-in serial-out shift register, the successor to our fixed 4-bit PISO. Accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per accepted beat. Bit order (MSB- or LSB-first) is selectable per word. A downstream valid/ready serial handshake allows back-pressure, and back-to-back words stream with no gap. Sits between parallel datapath logic and any bit-serial link or serializer stage.

Parameters:
WIDTH, 8, parallel word width in bits; legal range 2..64.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
load_valid  input  1  load_data/msb_first are valid.
load_ready  output  1  block can accept a word this cycle.
load_data  input  WIDTH  parallel word to serialise.
msb_first  input  1  1 = shift MSB first, 0 = LSB first; sampled with the word.
ser_out  output  1  current serial bit.
ser_valid  output  1  ser_out holds a valid bit.
ser_ready  input  1  downstream accepts ser_out this cycle.
busy  output  1  a word is held or being shifted.
frame_done  output  1  one-cycle pulse after the last bit of a word is accepted.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset values: ser_out=0, ser_valid=0, busy=0, frame_done=0, bit counter=0, shift register=0, FSM=IDLE. load_ready is 1 in the first cycle after reset.
- Load acceptance (load_valid & load_ready, called "load") latches load_data into the shift register and msb_first into the order flop. It also sets the counter to WIDTH.
- Load latency: the first bit appears on ser_out with ser_valid=1 in the cycle after the load.
- The first bit is load_data[WIDTH-1] when msb_first=1, and load_data[0] when msb_first=0.
- Beat: ser_valid & ser_ready. On each beat:
  - the register shifts toward the output end;
  - the vacated bit fills with 0;
  - the counter decrements by 1.
- While ser_ready=0, ser_out and ser_valid hold steady, with no change at all.
- FSM states:
  - IDLE: ser_valid=0, busy=0, load_ready=1. A load moves to SHIFT.
  - SHIFT: ser_valid=1, busy=1. A beat with counter==1 is the last bit.
    - If a load occurs in that same cycle, stay in SHIFT with the new word. Its first bit is valid next cycle, so there is no idle gap.
    - Otherwise go to IDLE (or PARITY when PARITY_EN is defined).
- load_ready in SHIFT is (counter==1) & ser_ready. It is never asserted earlier, so a load can never overwrite an in-flight word.
- load_valid while load_ready=0 is ignored. The source must hold the word stable until it is accepted.
- frame_done is registered: high for exactly one cycle, in the cycle after the final beat of a word. It coincides with the next word's first bit when words stream back to back.
- rst asserted mid-word aborts the word: no frame_done and all outputs go to their reset values next cycle. A load presented in the same cycle as rst is discarded.
- The counter never underflows. A beat in IDLE is impossible because ser_valid=0 there.

Optional Feature:
Macro PARITY_EN.
- Defined: adds a PARITY state after the last data bit.
  - ser_out = even parity (XOR) of the loaded word, ser_valid=1, busy=1.
  - load_ready=0 in PARITY until that parity beat is accepted. load_ready = ser_ready in PARITY, so a load can be accepted on the parity beat.
  - frame_done pulses after the parity beat instead of after the last data bit.
  - A frame is WIDTH+1 beats.
- Undefined: no PARITY state, a frame is WIDTH beats, and no parity logic is synthesised.

Test Plan:
1. WIDTH=8, rst high for 2 cycles, then low. Require: all outputs 0, load_ready=1, busy=0.
2. load 8'hA5 with msb_first=1 and ser_ready held 1. Require: ser_out sequence 1,0,1,0,0,1,0,1 starting the cycle after the load, then frame_done for 1 cycle, then IDLE.
3. load 8'hA5 with msb_first=0. Require: sequence 1,0,1,0,0,1,0,1 (LSB first). Load 8'h01 with msb_first=0. Require: sequence 1,0,0,0,0,0,0,0.
4. Toggle ser_ready 1,0,0,1,... while shifting 8'hC3. Require: ser_out constant through stall cycles, exactly 8 beats delivered, load_ready stays 0 until the last beat.
5. Hold load_valid high with words 8'hF0 then 8'h0F. Require: 16 consecutive valid bits with no gap, and frame_done after bit 8 and after bit 16.
6. Assert rst after 3 bits of 8'hFF. Require: next cycle ser_valid=0 and no frame_done. With PARITY_EN defined, 8'h07 must send 9 beats, the last ser_out=1.
